canny_frame_ctrl: RTL and testbench

Frame sequencer placed in front of and behind the canny_top pixel pipeline. It admits exactly W*H source pixels per frame through a valid/ready handshake and feeds them to the core. It then injects flush pixels to drain the chained 3x3 line buffers. It counts core outputs, forwards exactly W*H edge pixels downstream, tags the last one, and signals frame completion or flush failure.

---
 rtl/canny_ctrl_pkg.sv | 15 +
 rtl/canny_ctrl_cnt.sv | 25 ++
 rtl/canny_frame_ctrl.sv | 115 +++++++++++
 tb/tb_canny_frame_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/canny_ctrl_pkg.sv
// Shared types and helpers for the canny frame controller.
// Pure declarations; no timing or flow control of its own.
// Nothing here carries handshakes.
package canny_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} ctrl_state_t;

    localparam logic [7:0] FLUSH_VAL_DEF = 8'd0;

    // Bits needed to count from 0 up to and including w*h.
    function automatic int cnt_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/canny_ctrl_cnt.sv
// Saturating up-counter with synchronous clear and enable.
// Latency: count visible the cycle after the enabling edge.
// No backpressure; holds at MAX instead of wrapping.
module canny_ctrl_cnt #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer around canny_top: admits W*H pixels, flushes line buffers, forwards W*H edges (CANNY_CTRL_STATS_EN adds edge_count).
// Latency: core drive and downstream edge outputs are each registered, 1 cycle.
// Backpressure: s_ready closes after W*H transfers; downstream has none, excess core outputs are dropped.
module canny_frame_ctrl
    import canny_ctrl_pkg::*;
#(
    parameter int         W         = 3124,
    parameter int         H         = 3030,
    parameter logic [7:0] FLUSH_VAL = FLUSH_VAL_DEF,
    parameter int         FLUSH_MAX = 6 * W + 64,
    parameter int         CW        = cnt_w(W, H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    s_pixel,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [7:0]    core_pixel,
    output logic          core_valid,
    input  logic [7:0]    core_edge,
    input  logic          core_out_valid,
    output logic [7:0]    m_edge,
    output logic          m_valid,
    output logic          m_last,
    output logic          busy,
    output logic          frame_done,
    output logic          err_flush,
    output logic [CW-1:0] edge_count
);

    localparam int            FW      = $clog2(FLUSH_MAX + 1);
    localparam logic [CW-1:0] NPIX    = CW'(W * H);
    localparam logic [CW-1:0] NPIX_M1 = CW'(W * H - 1);
    localparam logic [FW-1:0] FMAX    = FW'(FLUSH_MAX);
    localparam logic [FW-1:0] FMAX_M1 = FW'(FLUSH_MAX - 1);

    ctrl_state_t   state, state_nxt;
    logic [CW-1:0] in_cnt, out_cnt;
    logic [FW-1:0] flush_cnt;
    logic          xfer, acc, clr;
    logic          in_done, out_done, flush_inj, flush_to;

    assign s_ready   = (state == RUN) && (in_cnt < NPIX);
    assign xfer      = s_valid && s_ready;
    assign acc       = core_out_valid && (out_cnt < NPIX) && ((state == RUN) || (state == FLUSH));
    assign clr       = (state == IDLE) && start;

    // "Done" includes the transfer/acceptance happening this very cycle.
    assign in_done   = (in_cnt == NPIX) || (xfer && (in_cnt == NPIX_M1));
    assign out_done  = (out_cnt == NPIX) || (acc && (out_cnt == NPIX_M1));
    assign flush_inj = (state == FLUSH) && !out_done;
    assign flush_to  = flush_inj && (flush_cnt == FMAX_M1);

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (in_done && out_done) state_nxt = DONE;
                else if (in_done)        state_nxt = FLUSH;
            end
            FLUSH:   if (out_done || flush_to) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_valid <= 1'b0;
            core_pixel <= 8'd0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_edge     <= 8'd0;
            err_flush  <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_valid <= xfer || flush_inj;
            if (xfer)           core_pixel <= s_pixel;
            else if (flush_inj) core_pixel <= FLUSH_VAL;
            m_valid    <= acc;
            m_last     <= acc && (out_cnt == NPIX_M1);
            if (acc)            m_edge <= core_edge;
            if (clr)            err_flush <= 1'b0;
            else if (flush_to)  err_flush <= 1'b1;
        end
    end

    canny_ctrl_cnt #(.WIDTH(CW), .MAX(NPIX)) u_in_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(xfer), .cnt(in_cnt)
    );

    canny_ctrl_cnt #(.WIDTH(CW), .MAX(NPIX)) u_out_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(acc), .cnt(out_cnt)
    );

    canny_ctrl_cnt #(.WIDTH(FW), .MAX(FMAX)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(flush_inj), .cnt(flush_cnt)
    );

`ifdef CANNY_CTRL_STATS_EN
    // Counted at acceptance, so it is already frozen once DONE is entered.
    canny_ctrl_cnt #(.WIDTH(CW), .MAX(NPIX)) u_edge_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(acc && (core_edge != 8'd0)), .cnt(edge_count)
    );
`else
    assign edge_count = '0;
`endif

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl at W=8, H=4, FLUSH_MAX=64 with a behavioural core stub.
// Stub modes: 20-deep pipeline (needs flush to drain), silent, and a scripted output burst.
module tb_canny_frame_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int FMAX = 64;
    localparam int D    = 20;

    typedef enum {STUB_PIPE, STUB_SILENT, STUB_BURST} stub_mode_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, core_out_valid = 1'b0;
    logic [7:0] s_pixel = 8'd0, core_edge = 8'd0;
    logic       s_ready, core_valid, m_valid, m_last, busy, frame_done, err_flush;
    logic [7:0] core_pixel, m_edge;
    logic [5:0] edge_count;

    int         vectors = 0, miscompares = 0;
    stub_mode_t mode = STUB_PIPE;
    logic [7:0] pipe[$], burst_q[$], exp_q[$];
    int         n_mv, n_ml, last_at, n_done, n_cv, n_cv_zero;

    canny_frame_ctrl #(.W(W), .H(H), .FLUSH_VAL(8'd0), .FLUSH_MAX(FMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .core_pixel(core_pixel), .core_valid(core_valid),
        .core_edge(core_edge), .core_out_valid(core_out_valid),
        .m_edge(m_edge), .m_valid(m_valid), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .err_flush(err_flush),
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_mv = 0; n_ml = 0; last_at = 0; n_done = 0; n_cv = 0; n_cv_zero = 0;
        pipe.delete(); burst_q.delete(); exp_q.delete();
    endtask

    // One clock: sample DUT outputs 1 time unit after the edge, then drive the stub core.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_valid) begin
            n_mv++;
            if (exp_q.size() > 0) check("m_edge", 32'(m_edge), 32'(exp_q.pop_front()));
            if (m_last) last_at = n_mv;
        end
        if (m_last) n_ml++;
        if (frame_done) n_done++;
        if (core_valid) begin
            n_cv++;
            if (core_pixel == 8'd0) n_cv_zero++;
        end
        core_out_valid = 1'b0;
        case (mode)
            STUB_PIPE: if (core_valid) begin
                pipe.push_back(core_pixel);
                if (pipe.size() > D) begin
                    core_edge      = pipe.pop_front();
                    core_out_valid = 1'b1;
                end
            end
            STUB_BURST: if (burst_q.size() > 0) begin
                core_edge      = burst_q.pop_front();
                core_out_valid = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input bit rnd, input int n, output int got);
        int   cyc = 0;
        logic pending;
        got = 0;
        while (got < n && cyc < 1000) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_pixel = 8'(8'h40 + got);
            pending = s_valid && s_ready;
            tick();
            if (pending) got++;
            cyc++;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (n_done == 0 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    // Full frame through the pipeline stub; source pixels must reappear in order.
    task automatic run_full(input bit rnd);
        int got;
        clear_mon();
        mode = STUB_PIPE;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(8'h40 + i));
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        feed(rnd, NPIX, got);
        check("xfers", got, NPIX);
        check("s_ready_drop", 32'(s_ready), 0);
        wait_done(500);
        check("done_seen", n_done, 1);
        // start coinciding with DONE->IDLE must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_fall", 32'(busy), 0);
        for (int i = 0; i < 3; i++) tick();
        check("busy_idle", 32'(busy), 0);
        check("m_valid_cnt", n_mv, NPIX);
        check("m_last_cnt", n_ml, 1);
        check("m_last_pos", last_at, NPIX);
        check("done_once", n_done, 1);
        check("err_flush", 32'(err_flush), 0);
        check("core_valid_cnt", n_cv, NPIX + D);
        check("flush_pixels", n_cv_zero, D);
    endtask

    initial begin
        int got;
        logic [7:0] b;
        clear_mon();

        // 1: reset and idle behaviour
        for (int i = 0; i < 3; i++) tick();
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_core_valid", 32'(core_valid), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err_flush", 32'(err_flush), 0);
        check("rst_edge_count", 32'(edge_count), 0);
        rst_n = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_s_ready", 32'(s_ready), 0);
        end
        s_valid = 1'b0;
        tick();

        // 2: back-to-back frame
        run_full(1'b0);

        // 3: 50% source valid
        run_full(1'b1);

        // 4: silent core -> flush timeout
        clear_mon();
        mode = STUB_SILENT;
        pulse_start();
        feed(1'b0, NPIX, got);
        wait_done(500);
        check("to_done", n_done, 1);
        check("to_err_flush", 32'(err_flush), 1);
        tick();
        check("to_err_sticky", 32'(err_flush), 1);
        check("to_core_valid_cnt", n_cv, NPIX + FMAX);
        check("to_flush_pixels", n_cv_zero, FMAX);
        check("to_m_valid_cnt", n_mv, 0);
        mode = STUB_PIPE;
        pulse_start();
        check("start_clears_err", 32'(err_flush), 0);

        // 5: reset mid-frame after 10 inputs, then a clean frame
        clear_mon();
        feed(1'b0, 10, got);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_core_valid", 32'(core_valid), 0);
        check("abort_s_ready", 32'(s_ready), 0);
        pipe.delete();
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_done", n_done, 0);
        run_full(1'b0);

        // 6: scripted burst of 40 outputs before any input; RUN goes straight to DONE
        clear_mon();
        mode = STUB_BURST;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            b = 8'd0;
            if (i == 0 || i == 3 || i == 7 || i == 12 || i == 20 || i == 30 || i == 31) b = 8'(8'h80 + i);
            if (i >= NPIX) b = 8'h11;
            burst_q.push_back(b);
            if (i < NPIX) exp_q.push_back(b);
        end
        for (int i = 0; i < 45; i++) tick();
        check("burst_m_valid_cnt", n_mv, NPIX);
        check("burst_m_last_pos", last_at, NPIX);
        feed(1'b0, NPIX, got);
        wait_done(100);
        for (int i = 0; i < 3; i++) tick();
        check("burst_done", n_done, 1);
        check("burst_no_flush", n_cv, NPIX);
        check("burst_m_last_cnt", n_ml, 1);
`ifdef CANNY_CTRL_STATS_EN
        check("edge_count", 32'(edge_count), 7);
`else
        check("edge_count", 32'(edge_count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
